uart_fifo_transceiver: RTL and testbench

//   Parametrised full-duplex UART (async serial) transceiver with RX and TX FIFOs.

---
 rtl/uart_fifo_transceiver.sv | 343 ++++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_transceiver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_transceiver.sv
// uart_fifo_transceiver
//   Full-duplex UART transceiver with an RX FIFO and a TX FIFO. Everything
//   runs on clk; bit timing comes from a free-running tick divider that
//   produces SAMPLE_RATIO ticks per bit. Errors are reported as sticky flags.
//
//   Optional feature macro: SERIAL_ECHO_EN
//     When defined, every byte pushed into the RX FIFO is also pushed into
//     the TX FIFO (bit-inverted when its MSB is set). The echo push has
//     priority over the user push. When the TX FIFO is full the echo is
//     dropped and overrun is raised. When undefined, RX and TX are
//     independent. The port list is the same in both builds.
//
// Ports
//   clk, rst              system clock, asynchronous active-high reset
//   din / dout            serial RX input (async) / serial TX output, idle high
//   tx_data/valid/ready   TX FIFO push handshake
//   rx_data/valid/ready   RX FIFO head (first-word-fall-through) and pop
//   tx_busy               TX shifter is inside a frame
//   rx_count, tx_count    FIFO occupancies, 0..FIFO_DEPTH
//   frame_err             sticky: stop bit sampled low
//   parity_err            sticky: parity mismatch
//   overrun               sticky: good byte lost because a FIFO was full
//   err_clr               clears the sticky flags; a same-cycle set wins

// Circular-buffer FIFO with first-word-fall-through read data.
module uart_fifo_transceiver_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // A push into a full FIFO is refused even when a pop happens the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

module uart_fifo_transceiver #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int SAMPLE_RATIO  = 16,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_MODE   = 0,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 16,
  localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  output logic                 dout,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 tx_busy,
  output logic [CNT_W-1:0]     rx_count,
  output logic [CNT_W-1:0]     tx_count,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 err_clr
);
  localparam int TICK_RATIO = CLK_FREQUENCY / BAUD_RATE / SAMPLE_RATIO;
  localparam int TICK_W     = (TICK_RATIO > 1) ? $clog2(TICK_RATIO) : 1;
  localparam int SW         = $clog2(SAMPLE_RATIO);
  localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(TICK_RATIO - 1);
  localparam logic [SW-1:0]     BIT_MAX   = SW'(SAMPLE_RATIO - 1);
  localparam logic [SW-1:0]     HALF_MAX  = SW'(SAMPLE_RATIO / 2 - 1);
  localparam logic [3:0]        LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]        LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  // ---------------- tick divider ----------------
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  assign tick = (tick_cnt == TICK_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // ---------------- receiver ----------------
  logic                 rx_meta, rx_sync, rx_prev;
  rx_state_t            rx_state, rx_next;
  logic [SW-1:0]        rx_tcnt;
  logic [3:0]           rx_bcnt;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par;
  logic                 rx_sample;
  logic                 rx_done, rx_par_bad, rx_good, rx_push;
  logic                 rx_full, rx_empty, rx_pop;

  // Synchroniser and edge-history are preset high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= din;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // START waits half a bit to land on the start-bit midpoint; later bits wait a full bit.
  assign rx_sample = tick && (rx_tcnt == ((rx_state == RX_START) ? HALF_MAX : BIT_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (rx_prev && !rx_sync) rx_next = RX_START;
      RX_START:  if (rx_sample) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_sample && (rx_bcnt == LAST_DATA))
                   rx_next = (PARITY_MODE != 0) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_sample) rx_next = RX_STOP;
      RX_STOP:   if (rx_sample) rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_tcnt  <= '0;
      rx_bcnt  <= '0;
      rx_shift <= '0;
      rx_par   <= 1'b0;
    end else begin
      if (rx_state == RX_IDLE) begin
        rx_tcnt <= '0;
        rx_bcnt <= '0;
      end else if (tick) begin
        rx_tcnt <= rx_sample ? '0 : rx_tcnt + 1'b1;
      end
      if (rx_state == RX_DATA && rx_sample) begin
        rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
        rx_bcnt  <= rx_bcnt + 1'b1;
      end
      if (rx_state == RX_PARITY && rx_sample) rx_par <= rx_sync;
    end
  end

  // Outcome at the stop-bit midpoint: frame error beats parity error beats overrun.
  assign rx_done    = (rx_state == RX_STOP) && rx_sample;
  assign rx_par_bad = (PARITY_MODE != 0) &&
                      (rx_par != ((PARITY_MODE == 1) ? ~(^rx_shift) : (^rx_shift)));
  assign rx_good    = rx_done && rx_sync && !rx_par_bad;
  assign rx_push    = rx_good && !rx_full;
  assign rx_pop     = rx_ready && !rx_empty;
  assign rx_valid   = !rx_empty;

  uart_fifo_transceiver_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .wdata (rx_shift),
    .pop   (rx_pop),
    .rdata (rx_data),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // ---------------- TX FIFO input (user push or echo) ----------------
  logic                 tx_push, tx_full, tx_empty, tx_pop, echo_drop;
  logic [DATA_BITS-1:0] tx_wdata, tx_head;

`ifdef SERIAL_ECHO_EN
  logic                 echo_push;
  logic [DATA_BITS-1:0] echo_data;

  assign echo_push = rx_push;
  assign echo_data = rx_shift[DATA_BITS-1] ? ~rx_shift : rx_shift;
  assign tx_ready  = !tx_full && !echo_push;
  assign tx_push   = echo_push || (tx_valid && tx_ready);
  assign tx_wdata  = echo_push ? echo_data : tx_data;
  assign echo_drop = echo_push && tx_full;
`else
  assign tx_ready  = !tx_full;
  assign tx_push   = tx_valid && tx_ready;
  assign tx_wdata  = tx_data;
  assign echo_drop = 1'b0;
`endif

  uart_fifo_transceiver_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (tx_wdata),
    .pop   (tx_pop),
    .rdata (tx_head),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // ---------------- transmitter ----------------
  tx_state_t            tx_state, tx_next;
  logic [SW-1:0]        tx_tcnt;
  logic [3:0]           tx_bcnt;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_bit_end;

  assign tx_bit_end = tick && (tx_tcnt == BIT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  // The last stop bit chains straight into the next START so queued bytes leave without a gap.
  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      TX_IDLE: if (!tx_empty) begin
        tx_next = TX_START;
        tx_pop  = 1'b1;
      end
      TX_START:  if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA:   if (tx_bit_end && (tx_bcnt == LAST_DATA))
                   tx_next = (PARITY_MODE != 0) ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
      TX_STOP:   if (tx_bit_end && (tx_bcnt == LAST_STOP)) begin
        if (!tx_empty) begin
          tx_next = TX_START;
          tx_pop  = 1'b1;
        end else begin
          tx_next = TX_IDLE;
        end
      end
      default:   tx_next = TX_IDLE;
    endcase
  end

  // dout and tx_busy are registered from the same state so they always move together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      dout     <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      if (tx_pop) begin
        tx_shift <= tx_head;
        tx_par   <= (PARITY_MODE == 1) ? ~(^tx_head) : (^tx_head);
        tx_tcnt  <= '0;
        tx_bcnt  <= '0;
      end else if (tx_state == TX_IDLE) begin
        tx_tcnt <= '0;
        tx_bcnt <= '0;
      end else begin
        if (tick) tx_tcnt <= tx_bit_end ? '0 : tx_tcnt + 1'b1;
        if (tx_bit_end) begin
          case (tx_state)
            TX_DATA: begin
              tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
              tx_bcnt  <= (tx_bcnt == LAST_DATA) ? '0 : tx_bcnt + 1'b1;
            end
            TX_STOP: tx_bcnt <= tx_bcnt + 1'b1;
            default: tx_bcnt <= tx_bcnt;
          endcase
        end
      end
      case (tx_state)
        TX_START:  dout <= 1'b0;
        TX_DATA:   dout <= tx_shift[0];
        TX_PARITY: dout <= tx_par;
        default:   dout <= 1'b1;
      endcase
      tx_busy <= (tx_state != TX_IDLE);
    end
  end

  // ---------------- sticky error flags ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= (rx_done && !rx_sync) || (frame_err && !err_clr);
      parity_err <= (rx_done && rx_sync && rx_par_bad) || (parity_err && !err_clr);
      overrun    <= (rx_good && rx_full) || echo_drop || (overrun && !err_clr);
    end
  end
endmodule

// File: tb/tb_uart_fifo_transceiver.sv
// tb_uart_fifo_transceiver
//   Bench for uart_fifo_transceiver. Two instances at 1.6 MHz / 10 kbaud
//   (160 clocks per bit): dut_a is 8N1 with 16-entry FIFOs, dut_b is 8E1
//   with 4-entry FIFOs. Expected bytes are queued when frames are driven
//   and checked when the DUT delivers them. Macro SERIAL_ECHO_EN adds the
//   echo check on dut_a.
`timescale 1ns/1ps
module tb_uart_fifo_transceiver;
  localparam int BIT = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       din_a, dout_a, tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a, tx_busy_a;
  logic       frame_err_a, parity_err_a, overrun_a, err_clr_a;
  logic [7:0] tx_data_a, rx_data_a;
  logic [4:0] rx_count_a, tx_count_a;

  logic       din_b, dout_b, tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b, tx_busy_b;
  logic       frame_err_b, parity_err_b, overrun_b, err_clr_b;
  logic [7:0] tx_data_b, rx_data_b;
  logic [2:0] rx_count_b, tx_count_b;

  uart_fifo_transceiver #(.CLK_FREQUENCY(1_600_000), .BAUD_RATE(10_000), .SAMPLE_RATIO(16),
                          .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .dout(dout_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .tx_busy(tx_busy_a), .rx_count(rx_count_a), .tx_count(tx_count_a),
    .frame_err(frame_err_a), .parity_err(parity_err_a), .overrun(overrun_a),
    .err_clr(err_clr_a)
  );

  uart_fifo_transceiver #(.CLK_FREQUENCY(1_600_000), .BAUD_RATE(10_000), .SAMPLE_RATIO(16),
                          .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .dout(dout_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .tx_busy(tx_busy_b), .rx_count(rx_count_b), .tx_count(tx_count_b),
    .frame_err(frame_err_b), .parity_err(parity_err_b), .overrun(overrun_b),
    .err_clr(err_clr_b)
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] rx_q_a[$];
  logic [7:0] rx_q_b[$];
  logic [7:0] tx_q_a[$];
  logic       rv_mid;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h want=0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic setDin(input int which, input logic v);
    if (which == 0) din_a = v;
    else            din_b = v;
  endtask

  // Drives one serial frame; the expected byte is queued up front when it should be accepted.
  task automatic applyStimulus(input int which, input logic [7:0] data, input logic use_par,
                               input logic par_bit, input logic stop_bit, input logic expect_push);
    if (expect_push) begin
      if (which == 0) rx_q_a.push_back(data);
      else            rx_q_b.push_back(data);
    end
    setDin(which, 1'b0);
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      setDin(which, data[i]);
      repeat (BIT) @(negedge clk);
    end
    if (use_par) begin
      setDin(which, par_bit);
      repeat (BIT) @(negedge clk);
    end
    setDin(which, stop_bit);
    repeat (60) @(negedge clk);
    rv_mid = (which == 0) ? rx_valid_a : rx_valid_b;
    repeat (BIT - 60) @(negedge clk);
    setDin(which, 1'b1);
  endtask

  task automatic popRx(input int which, input string tag);
    int         w = 0;
    logic [7:0] exp_byte;
    while (((which == 0) ? rx_valid_a : rx_valid_b) !== 1'b1 && w < 4000) begin
      @(negedge clk);
      w++;
    end
    if (((which == 0) ? rx_valid_a : rx_valid_b) !== 1'b1) begin
      checkOutput({tag, "_valid_timeout"}, 0, 1);
      return;
    end
    if (((which == 0) ? rx_q_a.size() : rx_q_b.size()) == 0) begin
      checkOutput({tag, "_unexpected_byte"}, 1, 0);
    end else begin
      exp_byte = (which == 0) ? rx_q_a.pop_front() : rx_q_b.pop_front();
      checkOutput(tag, (which == 0) ? rx_data_a : rx_data_b, exp_byte);
    end
    if (which == 0) rx_ready_a = 1'b1;
    else            rx_ready_b = 1'b1;
    @(negedge clk);
    rx_ready_a = 1'b0;
    rx_ready_b = 1'b0;
  endtask

  task automatic pushTx(input logic [7:0] v);
    @(negedge clk);
    tx_data_a  = v;
    tx_valid_a = 1'b1;
    checkOutput("tx_ready_before_push", tx_ready_a, 1);
    if (tx_ready_a) tx_q_a.push_back(v);
    @(negedge clk);
    tx_valid_a = 1'b0;
  endtask

  // Samples dut_a's dout at bit centres measured from the rise of tx_busy.
  task automatic captureTx(input string tag);
    int         w = 0;
    int         n = 0;
    int         k = 0;
    logic [9:0] bits = '1;
    while (tx_busy_a !== 1'b1 && w < 4000) begin
      @(negedge clk);
      w++;
    end
    if (tx_busy_a !== 1'b1) begin
      checkOutput({tag, "_busy_timeout"}, 0, 1);
      return;
    end
    checkOutput({tag, "_dout_low_at_busy"}, dout_a, 0);
    while (tx_busy_a === 1'b1 && n < 4000) begin
      if (k < 10 && n == BIT / 2 + BIT * k) begin
        bits[k] = dout_a;
        k++;
      end
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_start_bit"}, bits[0], 0);
    checkOutput({tag, "_stop_bit"}, bits[9], 1);
    if (tx_q_a.size() == 0) checkOutput({tag, "_unexpected_frame"}, 1, 0);
    else                    checkOutput({tag, "_data"}, bits[8:1], tx_q_a.pop_front());
    checkOutput({tag, "_busy_len_1591_to_1600"}, int'(n >= 1591 && n <= 1600), 1);
    checkOutput({tag, "_dout_idle"}, dout_a, 1);
  endtask

  task automatic pulseClear(input int which);
    @(negedge clk);
    if (which == 0) err_clr_a = 1'b1;
    else            err_clr_b = 1'b1;
    @(negedge clk);
    err_clr_a = 1'b0;
    err_clr_b = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #10_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] seq [5];
    seq = '{8'h11, 8'h5A, 8'hC3, 8'h80, 8'h7F};
    din_a = 1'b1; tx_valid_a = 1'b0; rx_ready_a = 1'b0; err_clr_a = 1'b0; tx_data_a = '0;
    din_b = 1'b1; tx_valid_b = 1'b0; rx_ready_b = 1'b0; err_clr_b = 1'b0; tx_data_b = '0;
    rv_mid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_dout_a", dout_a, 1);
    checkOutput("rst_tx_ready_a", tx_ready_a, 1);
    checkOutput("rst_rx_valid_a", rx_valid_a, 0);
    checkOutput("rst_rx_count_a", rx_count_a, 0);
    checkOutput("rst_tx_count_a", tx_count_a, 0);
    checkOutput("rst_tx_busy_a", tx_busy_a, 0);
    checkOutput("rst_flags_a", {frame_err_a, parity_err_a, overrun_a}, 0);
    checkOutput("rst_dout_b", dout_b, 1);
    checkOutput("rst_rx_valid_b", rx_valid_b, 0);
    checkOutput("rst_flags_b", {frame_err_b, parity_err_b, overrun_b}, 0);

    $display("[TB] 8N1 transmit 0x55");
    pushTx(8'h55);
    captureTx("tx55");
    checkOutput("tx_count_after_send", tx_count_a, 0);

    $display("[TB] 8N1 receive 0xA3");
    applyStimulus(0, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("rx_valid_before_stop_mid", rv_mid, 0);
    checkOutput("rx_count_a_one", rx_count_a, 1);
    popRx(0, "rxA3");
    checkOutput("rx_count_a_after_pop", rx_count_a, 0);

    $display("[TB] framing error");
    applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("frame_err_set", frame_err_a, 1);
    checkOutput("frame_err_no_push", rx_count_a, 0);
    pulseClear(0);
    checkOutput("frame_err_cleared", frame_err_a, 0);

    $display("[TB] start glitch");
    setDin(0, 1'b0);
    repeat (30) @(negedge clk);
    setDin(0, 1'b1);
    repeat (400) @(negedge clk);
    checkOutput("glitch_rx_count", rx_count_a, 0);
    checkOutput("glitch_flags", {frame_err_a, parity_err_a, overrun_a}, 0);

    $display("[TB] even parity error");
    applyStimulus(1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("parity_err_set", parity_err_b, 1);
    checkOutput("parity_err_rx_count", rx_count_b, 0);
    checkOutput("parity_err_no_frame_err", frame_err_b, 0);
    pulseClear(1);
    checkOutput("parity_err_cleared", parity_err_b, 0);

    $display("[TB] overrun with 4-deep FIFO");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, seq[i], 1'b1, ^seq[i], 1'b1, i < 4);
    end
    checkOutput("ovr_rx_count_full", rx_count_b, 4);
    checkOutput("ovr_flag", overrun_b, 1);
    checkOutput("ovr_no_parity_err", parity_err_b, 0);
    for (int i = 0; i < 4; i++) begin
      popRx(1, "ovr_pop");
    end
    checkOutput("ovr_rx_count_empty", rx_count_b, 0);
    checkOutput("ovr_rx_valid_low", rx_valid_b, 0);
    pulseClear(1);
    checkOutput("ovr_cleared", overrun_b, 0);

`ifdef SERIAL_ECHO_EN
    $display("[TB] echo 0x81");
    tx_q_a.push_back(8'h7E);
    fork
      applyStimulus(0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1);
      captureTx("echo81");
    join
    popRx(0, "rx81");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
